// File: rtl/store_align.sv
// store_align: turns one byte-addressed store (SB/SH/SW) into one or two
// word-aligned DMEM write beats with per-byte enables and lane-shifted data.
// Stores that cross a word boundary are split (or rejected when
// ALLOW_MISALIGNED is 0). All outputs come from registered state.
module store_align #(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_data,
  output logic        dmem_en,
  input  logic        dmem_ready,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_we,
  output logic [31:0] dmem_wdata,
  output logic        store_done,
  output logic        store_fault
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] base_q, base_d;
  logic [7:0]  mask8_q, mask8_d;
  logic [63:0] data64_q, data64_d;
  logic        done_q, done_d;
  logic        fault_q, fault_d;

  // Decoded view of the incoming request (only meaningful while IDLE).
  logic [3:0]  req_size_mask;
  logic        req_illegal;
  logic [31:0] req_data_m;
  logic [7:0]  req_mask8;
  logic [63:0] req_data64;
  logic        req_misaligned;
  logic        req_fault;

  // Byte-enable pattern for a store size; illegal codes yield 0000.
  function automatic logic [3:0] size_mask_of(input logic [2:0] f3);
    logic [3:0] m;
    m = 4'b0000;
    case (f3)
      3'b000:  m = 4'b0001;
      3'b001:  m = 4'b0011;
      3'b010:  m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Widen a 4-bit byte mask into a 32-bit bit mask.
  function automatic logic [31:0] byte_expand(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  // Decode the request: size, masked data, shifted lane mask and data, fault.
  always_comb begin
    req_size_mask  = size_mask_of(req_funct3);
    req_illegal    = (req_funct3 > 3'b010);
    req_data_m     = req_data & byte_expand(req_size_mask);
    req_mask8      = {4'b0000, req_size_mask} << req_addr[1:0];
    req_data64     = {32'h0, req_data_m} << {req_addr[1:0], 3'b000};
    req_misaligned = |req_mask8[7:4];
    req_fault      = req_illegal || (req_misaligned && !ALLOW_MISALIGNED);
  end

  // Next-state logic: accept in IDLE, advance beats on dmem_ready.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    mask8_d  = mask8_q;
    data64_d = data64_q;
    done_d   = 1'b0;
    fault_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_fault) begin
            fault_d = 1'b1;
          end else begin
            state_d  = BEAT0;
            base_d   = {req_addr[31:2], 2'b00};
            mask8_d  = req_mask8;
            data64_d = req_data64;
          end
        end
      end
      BEAT0: begin
        if (dmem_ready) begin
          if (|mask8_q[7:4]) begin
            state_d = BEAT1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      BEAT1: begin
        if (dmem_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from registered state; IDLE drives all zeros.
  always_comb begin
    req_ready   = (state_q == IDLE);
    dmem_en     = 1'b0;
    dmem_addr   = 32'h0;
    dmem_we     = 4'b0000;
    dmem_wdata  = 32'h0;
    store_done  = done_q;
    store_fault = fault_q;
    case (state_q)
      BEAT0: begin
        dmem_en    = 1'b1;
        dmem_addr  = base_q;
        dmem_we    = mask8_q[3:0];
        dmem_wdata = data64_q[31:0];
      end
      BEAT1: begin
        dmem_en    = 1'b1;
        dmem_addr  = base_q + 32'd4;
        dmem_we    = mask8_q[7:4];
        dmem_wdata = data64_q[63:32];
      end
      default: ;
    endcase
  end

  // Control registers: state and completion/fault pulses, async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      fault_q <= fault_d;
    end
  end

  // Store payload registers; only observed outside IDLE, so no reset needed.
  always_ff @(posedge clk) begin
    base_q   <= base_d;
    mask8_q  <= mask8_d;
    data64_q <= data64_d;
  end

endmodule

// File: tb/tb_store_align.sv
// Bench for store_align: two instances (misaligned allowed / rejected) share
// the same stimulus; a byte-level model predicts the beats of every store.
module tb_store_align;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_data;
  logic        dmem_ready;

  // Index 1: ALLOW_MISALIGNED=1, index 0: ALLOW_MISALIGNED=0.
  logic [1:0]       rdy_o;
  logic [1:0]       en_o;
  logic [1:0][31:0] addr_o;
  logic [1:0][3:0]  we_o;
  logic [1:0][31:0] wd_o;
  logic [1:0]       done_o;
  logic [1:0]       fault_o;

  int cmp_cnt = 0;
  int err_cnt = 0;

  store_align #(.ALLOW_MISALIGNED(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(rdy_o[1]),
    .req_addr(req_addr), .req_funct3(req_funct3), .req_data(req_data),
    .dmem_en(en_o[1]), .dmem_ready(dmem_ready), .dmem_addr(addr_o[1]),
    .dmem_we(we_o[1]), .dmem_wdata(wd_o[1]),
    .store_done(done_o[1]), .store_fault(fault_o[1])
  );

  store_align #(.ALLOW_MISALIGNED(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(rdy_o[0]),
    .req_addr(req_addr), .req_funct3(req_funct3), .req_data(req_data),
    .dmem_en(en_o[0]), .dmem_ready(dmem_ready), .dmem_addr(addr_o[0]),
    .dmem_we(we_o[0]), .dmem_wdata(wd_o[0]),
    .store_done(done_o[0]), .store_fault(fault_o[0])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: place each store byte at its own absolute address and group
  // the bytes by the word they land in.
  function automatic void calc(input logic [31:0] a, input logic [2:0] f3,
                               input logic [31:0] d, input bit allow,
                               output bit flt, output int nb,
                               output logic [1:0][31:0] ba,
                               output logic [1:0][3:0] bw,
                               output logic [1:0][31:0] bd);
    int size;
    logic [31:0] base, ab, w;
    int lane, j;
    flt = 0; nb = 0; ba = '0; bw = '0; bd = '0;
    size = 0;
    case (f3)
      3'd0: size = 1;
      3'd1: size = 2;
      3'd2: size = 4;
      default: flt = 1;
    endcase
    base  = a & 32'hFFFF_FFFC;
    ba[0] = base;
    ba[1] = base + 32'd4;
    for (int k = 0; k < size; k++) begin
      ab   = a + k;
      w    = ab & 32'hFFFF_FFFC;
      lane = int'(ab & 32'd3);
      j    = (w == base) ? 0 : 1;
      bw[j][lane] = 1'b1;
      bd[j][lane*8 +: 8] = d[k*8 +: 8];
      if (j + 1 > nb) nb = j + 1;
    end
    if (nb == 2 && !allow) flt = 1;
  endfunction

  // Model state per instance.
  bit               m_busy [2];
  int               m_cur  [2];
  int               m_nb   [2];
  logic [1:0][31:0] m_ba   [2];
  logic [1:0][3:0]  m_bw   [2];
  logic [1:0][31:0] m_bd   [2];
  bit               m_done [2];
  bit               m_fault[2];

  // Per-cycle compare of both instances against the model, then model step.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        chk($sformatf("rst_req_ready%0d", i), rdy_o[i], 1);
        chk($sformatf("rst_dmem_en%0d", i), en_o[i], 0);
        chk($sformatf("rst_dmem_addr%0d", i), addr_o[i], 0);
        chk($sformatf("rst_dmem_we%0d", i), we_o[i], 0);
        chk($sformatf("rst_dmem_wdata%0d", i), wd_o[i], 0);
        chk($sformatf("rst_store_done%0d", i), done_o[i], 0);
        chk($sformatf("rst_store_fault%0d", i), fault_o[i], 0);
        m_busy[i] = 0; m_done[i] = 0; m_fault[i] = 0; m_cur[i] = 0;
      end else begin
        bit nd, nf, flt;
        int nb;
        logic [1:0][31:0] ba, bd;
        logic [1:0][3:0]  bw;
        chk($sformatf("req_ready%0d", i), rdy_o[i], !m_busy[i]);
        chk($sformatf("dmem_en%0d", i), en_o[i], m_busy[i]);
        chk($sformatf("dmem_addr%0d", i), addr_o[i], m_busy[i] ? m_ba[i][m_cur[i]] : 32'h0);
        chk($sformatf("dmem_we%0d", i), we_o[i], m_busy[i] ? m_bw[i][m_cur[i]] : 4'h0);
        chk($sformatf("dmem_wdata%0d", i), wd_o[i], m_busy[i] ? m_bd[i][m_cur[i]] : 32'h0);
        chk($sformatf("store_done%0d", i), done_o[i], m_done[i]);
        chk($sformatf("store_fault%0d", i), fault_o[i], m_fault[i]);
        nd = 0; nf = 0;
        if (m_busy[i]) begin
          if (dmem_ready) begin
            if (m_cur[i] + 1 < m_nb[i]) m_cur[i]++;
            else begin m_busy[i] = 0; nd = 1; end
          end
        end else if (req_valid) begin
          calc(req_addr, req_funct3, req_data, (i == 1), flt, nb, ba, bw, bd);
          if (flt) nf = 1;
          else begin
            m_busy[i] = 1; m_cur[i] = 0; m_nb[i] = nb;
            m_ba[i] = ba; m_bw[i] = bw; m_bd[i] = bd;
          end
        end
        m_done[i] = nd; m_fault[i] = nf;
      end
    end
  end

  // Present a request until the misaligned-capable instance accepts it.
  task automatic issue(input logic [31:0] a, input logic [2:0] f, input logic [31:0] d);
    bit ok;
    ok = 0;
    req_addr = a; req_funct3 = f; req_data = d; req_valid = 1'b1;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (rdy_o[1]) ok = 1;
    end
    cmp_cnt++;
    if (!ok) begin
      err_cnt++;
      $display("FAIL issue_timeout: req_ready stayed 0, required 1");
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  initial begin
    bit flt;
    int nb;
    logic [1:0][31:0] ba, bd;
    logic [1:0][3:0]  bw;
    logic [2:0] f;

    rst_n = 1'b0; req_valid = 1'b0; req_addr = 0; req_funct3 = 0; req_data = 0;
    dmem_ready = 1'b1;

    // Hand-computed expectations pinning the reference model.
    calc(32'h0000_0203, 3'd0, 32'hFFFF_FFA5, 1, flt, nb, ba, bw, bd);
    chk("pin_sb_nb", nb, 1);
    chk("pin_sb_we", bw[0], 4'b1000);
    chk("pin_sb_wdata", bd[0], 32'hA500_0000);
    calc(32'h0000_0103, 3'd1, 32'h0000_1234, 1, flt, nb, ba, bw, bd);
    chk("pin_sh_nb", nb, 2);
    chk("pin_sh_we0", bw[0], 4'b1000);
    chk("pin_sh_wd0", bd[0], 32'h3400_0000);
    chk("pin_sh_addr1", ba[1], 32'h0000_0104);
    chk("pin_sh_we1", bw[1], 4'b0001);
    chk("pin_sh_wd1", bd[1], 32'h0000_0012);
    calc(32'hFFFF_FFFE, 3'd2, 32'h1122_3344, 1, flt, nb, ba, bw, bd);
    chk("pin_sw_addr0", ba[0], 32'hFFFF_FFFC);
    chk("pin_sw_we0", bw[0], 4'b1100);
    chk("pin_sw_wd0", bd[0], 32'h3344_0000);
    chk("pin_sw_addr1", ba[1], 32'h0000_0000);
    chk("pin_sw_we1", bw[1], 4'b0011);
    chk("pin_sw_wd1", bd[1], 32'h0000_1122);
    calc(32'h0000_0102, 3'd2, 32'h0, 0, flt, nb, ba, bw, bd);
    chk("pin_mis_fault", flt, 1);
    calc(32'h0000_0100, 3'd3, 32'h0, 1, flt, nb, ba, bw, bd);
    chk("pin_illegal_fault", flt, 1);

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed stores from the test plan (checked cycle by cycle).
    issue(32'h0000_0100, 3'd2, 32'hDEAD_BEEF);
    issue(32'h0000_0203, 3'd0, 32'hFFFF_FFA5);
    issue(32'h0000_0103, 3'd1, 32'h0000_1234);
    issue(32'hFFFF_FFFE, 3'd2, 32'h1122_3344);
    issue(32'h0000_0102, 3'd2, 32'hCAFE_F00D);
    issue(32'h0000_0100, 3'd3, 32'h5555_5555);
    repeat (4) @(posedge clk);
    #1;

    // SH at 0x3: stall BEAT1 for 3 cycles, then reset mid-beat.
    issue(32'h0000_0003, 3'd1, 32'h0000_ABCD);
    @(posedge clk); #1;
    dmem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("stall_en", en_o[1], 1);
    chk("stall_addr", addr_o[1], 32'h0000_0004);
    chk("stall_we", we_o[1], 4'b0001);
    chk("stall_wdata", wd_o[1], 32'h0000_00AB);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_en", en_o[1], 0);
    chk("rst_mid_we", we_o[1], 0);
    chk("rst_mid_addr", addr_o[1], 0);
    chk("rst_mid_wdata", wd_o[1], 0);
    chk("rst_mid_ready", rdy_o[1], 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    dmem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Randomized traffic with random DMEM back-pressure.
    for (int c = 0; c < 3000; c++) begin
      int r;
      req_valid = ($urandom_range(0, 2) != 0);
      req_addr  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC | $urandom_range(0, 3))
                                              : $urandom;
      r = $urandom_range(0, 9);
      if (r < 3)      f = 3'd0;
      else if (r < 6) f = 3'd1;
      else if (r < 9) f = 3'd2;
      else            f = 3'($urandom_range(3, 7));
      req_funct3 = f;
      req_data   = $urandom;
      dmem_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    req_valid  = 1'b0;
    dmem_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
